inject_merge: RTL

- Parametrised N-channel successor to the two-input OR combiner.
- Merges NCH valid/ready input channels of WIDTH bits into one output stream.
- Two runtime modes: OR-combine, where all valid channels are merged into one beat, and round-robin pass-through, where one channel is granted per beat.
- Output is buffered in a 2-entry registered FIFO, so there is no combinational path from out_ready to in_ready.

---
 rtl/inject_merge.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/inject_merge.sv
`default_nettype none
// ============================================================================
// Module   : inject_merge
// Purpose  : Merges NCH valid/ready input channels into one output stream.
//            Two runtime modes: OR-combine (every valid channel merged into a
//            single beat) and round-robin pass-through (one channel per beat).
//            Output is held in a 2-entry registered FIFO so in_ready never
//            depends on out_ready.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            or_mode           - requested mode (1 = OR, 0 = round-robin)
//            in_valid/in_ready - per-channel handshake (bit k = channel k)
//            in_data           - channel k at [k*WIDTH +: WIDTH]
//            out_valid/out_ready/out_data/out_src - FIFO head beat
//            mode_q            - mode currently in force
//            beat_cnt          - saturating count of output transfers
// Revision : 1.0 - initial release
// ============================================================================
module inject_merge #(
  parameter int NCH   = 2,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 or_mode,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [NCH-1:0]       out_src,
  output logic                 mode_q,
  output logic [CNT_W-1:0]     beat_cnt
);

  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NCH - 1);

  // FIFO storage: head entry drives the outputs, tail is the second slot.
  logic [1:0]       count_q,     count_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic [NCH-1:0]   head_src_q,  head_src_d;
  logic [WIDTH-1:0] tail_data_q, tail_data_d;
  logic [NCH-1:0]   tail_src_q,  tail_src_d;
  logic             mode_d;
  logic [PTR_W-1:0] ptr_q,       ptr_d;
  logic [CNT_W-1:0] beat_cnt_q,  beat_cnt_d;

  logic             space;
  logic             found;
  logic [PTR_W-1:0] grant_idx;
  logic [NCH-1:0]   grant_oh;
  logic [NCH-1:0]   accept;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;

  // Round-robin arbiter: lowest valid channel at or above ptr, otherwise the
  // lowest valid channel overall (the wrap-around). Descending loops leave
  // the lowest matching index as the final assignment.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (in_valid[k] && (PTR_W'(k) >= ptr_q)) begin
        grant_idx = PTR_W'(k);
        found     = 1'b1;
      end
    end
    if (!found) begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (in_valid[k]) begin
          grant_idx = PTR_W'(k);
          found     = 1'b1;
        end
      end
    end
    grant_oh = found ? (NCH'(1) << grant_idx) : '0;
  end

  // Space comes from the registered count only; rst_n gating keeps in_ready
  // low for the whole reset window.
  assign space    = (count_q != 2'd2) & rst_n;
  assign in_ready = mode_q ? {NCH{space}} : (space ? grant_oh : '0);
  assign accept   = in_valid & in_ready;
  assign push     = |accept;
  assign pop      = (count_q != 2'd0) & out_ready;

  // The accepted mask is all valid channels in OR mode and the one-hot grant
  // in round-robin mode, so one OR-reduction serves both modes.
  always_comb begin
    push_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (accept[k]) begin
        push_data = push_data | in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_src_d  = head_src_q;
    tail_data_d = tail_data_q;
    tail_src_d  = tail_src_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_data_d = push_data;
          head_src_d  = accept;
          count_d     = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_data_d = push_data;
          head_src_d  = accept;
        end else if (push) begin
          tail_data_d = push_data;
          tail_src_d  = accept;
          count_d     = 2'd2;
        end else if (pop) begin
          head_data_d = '0;
          head_src_d  = '0;
          count_d     = 2'd0;
        end
      end
      2'd2: begin
        // No push is possible while full.
        if (pop) begin
          head_data_d = tail_data_q;
          head_src_d  = tail_src_q;
          tail_data_d = '0;
          tail_src_d  = '0;
          count_d     = 2'd1;
        end
      end
      default: begin
        count_d = 2'd0;
      end
    endcase
  end

  // Mode only switches when nothing is buffered and nothing enters, so a
  // mode change can never split or reorder queued beats.
  assign mode_d = ((count_q == 2'd0) && !push) ? or_mode : mode_q;

  assign ptr_d = (!mode_q && push) ? ((grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1)
                                   : ptr_q;

  assign beat_cnt_d = (pop && (beat_cnt_q != '1)) ? beat_cnt_q + 1'b1 : beat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      head_data_q <= '0;
      head_src_q  <= '0;
      tail_data_q <= '0;
      tail_src_q  <= '0;
      mode_q      <= 1'b0;
      ptr_q       <= '0;
      beat_cnt_q  <= '0;
    end else begin
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_src_q  <= head_src_d;
      tail_data_q <= tail_data_d;
      tail_src_q  <= tail_src_d;
      mode_q      <= mode_d;
      ptr_q       <= ptr_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_data_q;
  assign out_src   = head_src_q;
  assign beat_cnt  = beat_cnt_q;

endmodule
`default_nettype wire
